dr_prech_fault_sequencer: RTL and testbench

- Generates the precharge/evaluate phase enables `prech1` and `prech2` for one dual-rail bidirectional IO tile in the W_IO column.
- Consumes that tile's `F_masked1` / `F_masked2` encoding-check flags and the external `DR_fault` line.
- Counts detected faults. At a threshold it locks the IO into permanent precharge, so both `prech` lines stay low and all fabric-bound rails are zeroed, until software clears the lockout.
- Sits between the IO tile and the top-level fault/alarm logic, clocked by `UserCLK`.

---
 rtl/dr_prech_fault_sequencer.sv | 164 ++++++++++++++++
 tb/tb_dr_prech_fault_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dr_prech_fault_sequencer.sv
// Purpose: precharge/evaluate phase sequencer for one dual-rail IO tile, with fault counting and lockout.
// Latency: all outputs registered; a fault event shows on fault_count/fault_alarm/locked one cycle later.
// Backpressure: none; en is sampled only at IDLE exit and round end. Optional macro DR_FAULT_SYNC_EN adds a 2-flop DR_fault synchroniser.
module dr_prech_fault_sequencer #(
  parameter int PRECH_CYCLES   = 2,
  parameter int EVAL_CYCLES    = 3,
  parameter int SETTLE_CYCLES  = 1,
  parameter int CNT_W          = 8,
  parameter int LOCK_THRESHOLD = 3
) (
  input  logic             UserCLK,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_fault,
  input  logic             F_masked1,
  input  logic             F_masked2,
  input  logic             DR_fault,
  output logic             prech1,
  output logic             prech2,
  output logic [2:0]       phase,
  output logic             round_done,
  output logic             fault_alarm,
  output logic             locked,
  output logic [CNT_W-1:0] fault_count
);

  localparam int MAXC = (PRECH_CYCLES > EVAL_CYCLES) ? PRECH_CYCLES : EVAL_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_EV1  = 3'd2,
    S_EV2  = 3'd3,
    S_LOCK = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [CNT_W-1:0] count_nxt, count_inc;
  logic             alarm_nxt;
  logic             dr_det;
  logic             in_window;
  logic             fault_ev;

`ifdef DR_FAULT_SYNC_EN
  logic dr_s1, dr_s2;

  // Two-flop synchroniser: DR_fault comes from outside the UserCLK domain.
  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      dr_s1 <= 1'b0;
      dr_s2 <= 1'b0;
    end else begin
      dr_s1 <= DR_fault;
      dr_s2 <= dr_s1;
    end
  end

  assign dr_det = dr_s2;
`else
  assign dr_det = DR_fault;
`endif

  // Next-state, phase timer and fault bookkeeping.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    count_nxt = fault_count;
    alarm_nxt = fault_alarm;

    // Timer counts remaining cycles; index >= SETTLE_CYCLES once it drops to the window edge.
    in_window = (timer <= TW'(EVAL_CYCLES - 1 - SETTLE_CYCLES));
    count_inc = (fault_count == {CNT_W{1'b1}}) ? fault_count : fault_count + 1'b1;

    fault_ev = 1'b0;
    case (state)
      S_PRE:   fault_ev = dr_det;
      S_EV1:   fault_ev = dr_det | (F_masked1 & in_window);
      S_EV2:   fault_ev = dr_det | ((F_masked1 | F_masked2) & in_window);
      default: fault_ev = 1'b0;
    endcase

    case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = S_PRE;
          timer_nxt = TW'(PRECH_CYCLES - 1);
        end
      end
      S_PRE: begin
        if (timer == '0) begin
          state_nxt = S_EV1;
          timer_nxt = TW'(EVAL_CYCLES - 1);
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_EV1: begin
        if (timer == '0) begin
          state_nxt = S_EV2;
          timer_nxt = TW'(EVAL_CYCLES - 1);
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_EV2: begin
        if (timer == '0) begin
          state_nxt = en ? S_PRE : S_IDLE;
          timer_nxt = TW'(PRECH_CYCLES - 1);
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      S_LOCK: begin
        timer_nxt = '0;
        if (clr_fault) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase

    // Clear dominates a coincident fault event, so it can never trigger LOCK.
    if (clr_fault) begin
      count_nxt = '0;
      alarm_nxt = 1'b0;
    end else if (fault_ev) begin
      count_nxt = count_inc;
      alarm_nxt = 1'b1;
      if (count_inc >= CNT_W'(LOCK_THRESHOLD)) begin
        state_nxt = S_LOCK;
        timer_nxt = '0;
      end
    end
  end

  // State, timer and registered outputs decoded from the next state.
  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      prech1      <= 1'b0;
      prech2      <= 1'b0;
      phase       <= 3'd0;
      round_done  <= 1'b0;
      locked      <= 1'b0;
      fault_alarm <= 1'b0;
      fault_count <= '0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      prech1      <= (state_nxt == S_EV1) || (state_nxt == S_EV2);
      prech2      <= (state_nxt == S_EV2);
      phase       <= state_nxt;
      round_done  <= (state_nxt == S_EV2) && (timer_nxt == '0);
      locked      <= (state_nxt == S_LOCK);
      fault_alarm <= alarm_nxt;
      fault_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_dr_prech_fault_sequencer.sv
// Purpose: directed self-checking bench for dr_prech_fault_sequencer (default parameters plus a CNT_W=2 copy).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: not applicable; every wait is bounded by a cycle budget.
module tb_dr_prech_fault_sequencer;

  logic       UserCLK = 1'b0;
  logic       rst, en, clr_fault, F_masked1, F_masked2, DR_fault;
  logic       prech1, prech2, round_done, fault_alarm, locked;
  logic [2:0] phase;
  logic [7:0] fault_count;
  logic       s_prech1, s_prech2, s_round_done, s_fault_alarm, s_locked;
  logic [2:0] s_phase;
  logic [1:0] s_fault_count;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DR_FAULT_SYNC_EN
  localparam int DR_LAT = 3;
`else
  localparam int DR_LAT = 1;
`endif

  always #5 UserCLK = ~UserCLK;

  dr_prech_fault_sequencer u_dut (
    .UserCLK(UserCLK), .rst(rst), .en(en), .clr_fault(clr_fault),
    .F_masked1(F_masked1), .F_masked2(F_masked2), .DR_fault(DR_fault),
    .prech1(prech1), .prech2(prech2), .phase(phase), .round_done(round_done),
    .fault_alarm(fault_alarm), .locked(locked), .fault_count(fault_count)
  );

  dr_prech_fault_sequencer #(.CNT_W(2), .LOCK_THRESHOLD(3)) u_sat (
    .UserCLK(UserCLK), .rst(rst), .en(en), .clr_fault(clr_fault),
    .F_masked1(F_masked1), .F_masked2(F_masked2), .DR_fault(DR_fault),
    .prech1(s_prech1), .prech2(s_prech2), .phase(s_phase), .round_done(s_round_done),
    .fault_alarm(s_fault_alarm), .locked(s_locked), .fault_count(s_fault_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge UserCLK);
    #1;
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] p);
    int n = 0;
    while (phase !== p && n < 30) begin
      tick();
      n++;
    end
    check(tag, 32'(phase), 32'(p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_ph [8];
    exp_ph = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};

    rst = 1'b0; en = 1'b0; clr_fault = 1'b0;
    F_masked1 = 1'b0; F_masked2 = 1'b0; DR_fault = 1'b0;

    // Reset state.
    #2;
    check("rst_phase", 32'(phase), 0);
    check("rst_prech", {prech1, prech2}, 0);
    check("rst_flags", {round_done, fault_alarm, locked}, 0);
    check("rst_count", 32'(fault_count), 0);
    check("rst_sat", {s_prech1, s_prech2, s_phase, s_round_done, s_fault_alarm, s_locked, s_fault_count}, 0);
    tick(); tick();
    rst = 1'b1; en = 1'b1;

    // Two clean rounds.
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t1_phase", 32'(phase), 32'(exp_ph[i % 8]));
      check("t1_prech1", 32'(prech1), 32'(exp_ph[i % 8] >= 3'd2));
      check("t1_prech2", 32'(prech2), 32'(exp_ph[i % 8] == 3'd3));
      check("t1_round_done", 32'(round_done), 32'((i % 8) == 7));
    end
    check("t1_count", 32'(fault_count), 0);

    // F_masked1 in settle window ignored, then counted.
    wait_phase("t2_ev1", 3'd2);
    F_masked1 = 1'b1; tick(); F_masked1 = 1'b0;
    check("t2_settle_count", 32'(fault_count), 0);
    check("t2_settle_alarm", 32'(fault_alarm), 0);
    F_masked1 = 1'b1; tick(); F_masked1 = 1'b0;
    check("t2_count", 32'(fault_count), 1);
    check("t2_alarm", 32'(fault_alarm), 1);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    check("t2_clr_count", 32'(fault_count), 0);
    check("t2_clr_alarm", 32'(fault_alarm), 0);
    check("t2_clr_phase", 32'(phase), 3);

    // F_masked2 ignored in EV1, counted at EV2 index 2.
    wait_phase("t3_ev1", 3'd2);
    F_masked2 = 1'b1; tick(); tick(); tick(); F_masked2 = 1'b0;
    check("t3_ev1_count", 32'(fault_count), 0);
    check("t3_ev2_phase", 32'(phase), 3);
    tick(); tick();
    F_masked2 = 1'b1; tick(); F_masked2 = 1'b0;
    check("t3_count", 32'(fault_count), 1);
    check("t3_phase", 32'(phase), 1);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    check("t3_clr_count", 32'(fault_count), 0);

    // Three DR_fault pulses force LOCK.
    for (int k = 0; k < 3; k++) begin
      DR_fault = 1'b1; tick(); DR_fault = 1'b0;
      tick();
    end
    tick(); tick(); tick();
    check("t4_phase", 32'(phase), 4);
    check("t4_locked", 32'(locked), 1);
    check("t4_prech", {prech1, prech2}, 0);
    check("t4_count", 32'(fault_count), 3);
    check("t4_alarm", 32'(fault_alarm), 1);
    tick(); tick(); tick();
    check("t4_hold_phase", 32'(phase), 4);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    check("t4_clr_phase", 32'(phase), 0);
    check("t4_clr_count", 32'(fault_count), 0);
    check("t4_clr_locked", 32'(locked), 0);
    tick();
    check("t4_restart", 32'(phase), 1);

    // Fault coincident with clear: clear wins.
    wait_phase("t5_ev1", 3'd2);
    tick();
    F_masked1 = 1'b1; DR_fault = 1'b1; clr_fault = 1'b1;
    tick();
    F_masked1 = 1'b0; DR_fault = 1'b0;
    check("t5_coin_count", 32'(fault_count), 0);
    check("t5_coin_alarm", 32'(fault_alarm), 0);
    check("t5_coin_phase", 32'(phase), 2);
    tick(); tick(); tick();
    clr_fault = 1'b0;

    // Repeated faults after clearing: narrow counter tops out at 3.
    DR_fault = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    DR_fault = 1'b0;
    tick(); tick(); tick(); tick();
    check("t5_sat_count", 32'(s_fault_count), 3);
    check("t5_sat_locked", 32'(s_locked), 1);
    check("t5_main_count", 32'(fault_count), 3);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    check("t5_sat_clr", 32'(s_fault_count), 0);

    // Async reset in EV2 drops prech lines before the next edge.
    wait_phase("t6_ev2", 3'd3);
    check("t6_ev2_prech", {prech1, prech2}, 3);
    rst = 1'b0;
    #1;
    check("t6_async_prech", {prech1, prech2}, 0);
    check("t6_async_phase", 32'(phase), 0);
    #2;
    rst = 1'b1;

    // DR_fault latency from sample edge to fault_count.
    tick();
    check("t6_pre", 32'(phase), 1);
    DR_fault = 1'b1; tick(); DR_fault = 1'b0;
    for (int k = 1; k <= DR_LAT; k++) begin
      if (k > 1) tick();
      check("t6_dr_latency", 32'(fault_count), 32'(k == DR_LAT));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
